sram_dp: RTL and testbench

SRAM_DP -- requirements
Module: sram_dp

---
 rtl/sram_dp.sv | 86 ++++++++
 tb/tb_sram_dp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp.sv
// sram_dp: two request/response ports sharing one word-wide SRAM, round-robin
// arbitrated, one grant per edge, fixed-latency read-first response pipeline.
module sram_dp #(
    parameter int          ADDR_WIDTH = 14,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_wstrb,
    output logic [31:0] a_rdata,
    output logic        a_ready,
    output logic        a_err,
    input  logic        b_valid,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_wstrb,
    output logic [31:0] b_rdata,
    output logic        b_ready,
    output logic        b_err
);
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  a_busy, b_busy, last_b;
    logic                  gnt_a, gnt_b, gnt;
    logic [31:0]           r_addr, r_wdata;
    logic [3:0]            r_wstrb;
    logic [32:0]           diff;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  pv [LATENCY];
    logic                  pp [LATENCY];
    logic                  pe [LATENCY];
    logic [31:0]           pd [LATENCY];

    // a wins a tie only when b was granted last
    always_comb begin
        gnt_a    = a_valid && !a_busy && (!(b_valid && !b_busy) || last_b);
        gnt_b    = b_valid && !b_busy && !gnt_a;
        gnt      = gnt_a || gnt_b;
        r_addr   = gnt_b ? b_addr : a_addr;
        r_wdata  = gnt_b ? b_wdata : a_wdata;
        r_wstrb  = gnt_b ? b_wstrb : a_wstrb;
        diff     = {1'b0, r_addr} - {1'b0, BASE_ADDR};
        in_range = !diff[32] && diff[31:ADDR_WIDTH+2] == '0 && diff[1:0] == 2'b00;
        idx      = diff[ADDR_WIDTH+1:2];
    end

    always_ff @(posedge clk) begin
        if (!rst && gnt && in_range && r_wstrb != 4'b0000)
            for (int i = 0; i < 4; i++)
                if (r_wstrb[i]) mem[idx][8*i +: 8] <= r_wdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_busy <= 1'b0;
            b_busy <= 1'b0;
            last_b <= 1'b1;
            for (int i = 0; i < LATENCY; i++) pv[i] <= 1'b0;
        end else begin
            a_busy <= gnt_a || (a_busy && !a_ready);
            b_busy <= gnt_b || (b_busy && !b_ready);
            if (gnt) last_b <= gnt_b;
            pv[0] <= gnt;
            for (int i = 1; i < LATENCY; i++) pv[i] <= pv[i-1];
        end
        pp[0] <= gnt_b;
        pe[0] <= !in_range;
        pd[0] <= in_range ? mem[idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            pp[i] <= pp[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign a_ready = pv[LATENCY-1] && !pp[LATENCY-1];
    assign b_ready = pv[LATENCY-1] && pp[LATENCY-1];
    assign a_rdata = a_ready ? pd[LATENCY-1] : 32'h0;
    assign b_rdata = b_ready ? pd[LATENCY-1] : 32'h0;
    assign a_err   = a_ready && pe[LATENCY-1];
    assign b_err   = b_ready && pe[LATENCY-1];
endmodule

// File: tb/tb_sram_dp.sv
// tb_sram_dp: randomized self-checking bench for sram_dp against an
// array-based memory model with address-range and latency rules.
module tb_sram_dp;
    localparam int          AW   = 4;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          NW   = 2**AW;

    logic        clk = 0, rst = 1;
    logic        a_valid = 0, b_valid = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic [3:0]  a_wstrb = 0, b_wstrb = 0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, b_ready, a_err, b_err;

    int          checks = 0, errors = 0;
    int          overlap = 0, idle_bad = 0;
    logic [31:0] model [NW];
    bit          order_q [$];

    sram_dp #(.ADDR_WIDTH(AW), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
        .a_rdata(a_rdata), .a_ready(a_ready), .a_err(a_err),
        .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
        .b_rdata(b_rdata), .b_ready(b_ready), .b_err(b_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_ready && b_ready) overlap++;
        if (!a_ready && (a_rdata !== 32'h0 || a_err !== 1'b0)) idle_bad++;
        if (!b_ready && (b_rdata !== 32'h0 || b_err !== 1'b0)) idle_bad++;
        if (a_ready) order_q.push_back(1'b0);
        if (b_ready) order_q.push_back(1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic bit in_rng(input logic [31:0] addr);
        return addr >= BASE && addr < BASE + 4 * NW && addr % 4 == 0;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr - BASE) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, wd, input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic xact(input bit p, input logic [31:0] addr, wd, input logic [3:0] st,
                        input bit hold, output logic [31:0] rd, output logic er, output int n);
        bit rdy;
        n = 0;
        if (p) begin b_valid = 1; b_addr = addr; b_wdata = wd; b_wstrb = st; end
        else   begin a_valid = 1; a_addr = addr; a_wdata = wd; a_wstrb = st; end
        do begin
            @(posedge clk); @(negedge clk); n++;
            rdy = p ? b_ready : a_ready;
        end while (!rdy && n < 20);
        rd = p ? b_rdata : a_rdata;
        er = p ? b_err : a_err;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL timeout port %0d addr %h: ready not seen in %0d cycles, required", p, addr, n);
        end
        if (!hold) begin
            if (p) b_valid = 0; else a_valid = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1; a_valid = 1; a_addr = 32'h0; a_wstrb = 0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got a=%b b=%b want 0", a_ready, b_ready); end
        if (a_err !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL reset_err got a=%b b=%b want 0", a_err, b_err); end
        if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_a_rdata got %h want 0", a_rdata); end
        if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_b_rdata got %h want 0", b_rdata); end
        rst = 0; n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (!a_ready && n < 20);
        checks += 3;
        if (n != LAT) begin errors++; $display("FAIL first_grant latency got %0d want %0d", n, LAT); end
        if (a_err !== 1'b1) begin errors++; $display("FAIL first_grant err got %b want 1", a_err); end
        if (a_rdata !== 32'h0) begin errors++; $display("FAIL first_grant rdata got %h want 0", a_rdata); end
        a_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_init();
        logic [31:0] rd, wd; logic er; int n;
        for (int i = 0; i < NW; i++) begin
            wd = $urandom;
            xact(i[0], BASE + 4 * i, wd, 4'hF, 0, rd, er, n);
            model[i] = wd;
            checks += 2;
            if (er !== 1'b0) begin errors++; $display("FAIL init[%0d] err got %b want 0", i, er); end
            if (n != LAT) begin errors++; $display("FAIL init[%0d] latency got %0d want %0d", i, n, LAT); end
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd, old; logic er; int n;
        old = model[4];
        xact(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, n);
        model[4] = 32'hDEAD_BEEF;
        checks += 2;
        if (rd !== old) begin errors++; $display("FAIL bw_first rdata got %h want %h", rd, old); end
        if (n != LAT) begin errors++; $display("FAIL bw_first latency got %0d want %0d", n, LAT); end
        xact(0, BASE + 32'h10, 32'h0000_00AA, 4'h1, 0, rd, er, n);
        model[4] = 32'hDEAD_BEAA;
        checks += 3;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bw_second rdata got %h want deadbeef", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL bw_second err got %b want 0", er); end
        if (n != LAT) begin errors++; $display("FAIL bw_second latency got %0d want %0d", n, LAT); end
        xact(0, BASE + 32'h10, 32'h0, 4'h0, 0, rd, er, n);
        checks += 2;
        if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL bw_read rdata got %h want deadbeaa", rd); end
        if (n != LAT) begin errors++; $display("FAIL bw_read latency got %0d want %0d", n, LAT); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int n;
        logic [31:0] addrs [4];
        addrs[0] = BASE + 32'h40; addrs[1] = BASE + 32'h2;
        addrs[2] = BASE - 32'h4;  addrs[3] = BASE + 32'h3C;
        for (int i = 0; i < 4; i++) begin
            xact(i[0], addrs[i], 32'h5555_AAAA, i == 1 ? 4'hF : 4'h0, 0, rd, er, n);
            checks += 3;
            if (er !== !in_rng(addrs[i])) begin errors++; $display("FAIL err[%h] err got %b want %b", addrs[i], er, !in_rng(addrs[i])); end
            if (rd !== (in_rng(addrs[i]) ? model[widx(addrs[i])] : 32'h0)) begin errors++; $display("FAIL err[%h] rdata got %h", addrs[i], rd); end
            if (n != LAT) begin errors++; $display("FAIL err[%h] latency got %0d want %0d", addrs[i], n, LAT); end
        end
        xact(1, BASE, 32'h0, 4'h0, 0, rd, er, n);
        checks++;
        if (rd !== model[0]) begin errors++; $display("FAIL err_untouched rdata got %h want %h", rd, model[0]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, addr, exp_rd; logic [3:0] st; logic er, exp_er; int n, sel; bit p;
        for (int k = 0; k < 40; k++) begin
            p = 1'($urandom % 2);
            sel = $urandom % 8;
            addr = sel == 0 ? BASE + 4 * NW + 4 * ($urandom % 64) :
                   sel == 1 ? BASE + 4 * ($urandom % NW) + 1 + ($urandom % 3) :
                   sel == 2 ? BASE - 4 - 4 * ($urandom % 64) :
                              BASE + 4 * ($urandom % NW);
            wd = $urandom;
            st = ($urandom % 2) ? 4'($urandom) : 4'h0;
            exp_er = !in_rng(addr);
            exp_rd = exp_er ? 32'h0 : model[widx(addr)];
            xact(p, addr, wd, st, 0, rd, er, n);
            if (!exp_er && st != 0) model[widx(addr)] = merge(exp_rd, wd, st);
            checks += 3;
            if (rd !== exp_rd) begin errors++; $display("FAIL rnd[%0d] addr %h rdata got %h want %h", k, addr, rd, exp_rd); end
            if (er !== exp_er) begin errors++; $display("FAIL rnd[%0d] addr %h err got %b want %b", k, addr, er, exp_er); end
            if (n != LAT) begin errors++; $display("FAIL rnd[%0d] latency got %0d want %0d", k, n, LAT); end
        end
    endtask

    task automatic test_simul();
        logic [31:0] ra, rb; logic ea, eb; int na, nb;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        fork
            xact(0, BASE + 12, 32'h0, 4'h0, 0, ra, ea, na);
            xact(1, BASE + 20, 32'h0, 4'h0, 0, rb, eb, nb);
        join
        checks += 4;
        if (na != LAT) begin errors++; $display("FAIL simul a latency got %0d want %0d", na, LAT); end
        if (nb != LAT + 1) begin errors++; $display("FAIL simul b latency got %0d want %0d", nb, LAT + 1); end
        if (ra !== model[3] || ea !== 1'b0) begin errors++; $display("FAIL simul a rdata got %h/%b want %h/0", ra, ea, model[3]); end
        if (rb !== model[5] || eb !== 1'b0) begin errors++; $display("FAIL simul b rdata got %h/%b want %h/0", rb, eb, model[5]); end
    endtask

    task automatic test_back_to_back();
        int same, na;
        order_q.delete();
        fork
            begin : pa
                logic [31:0] rd, wd, exp; logic [3:0] st; logic er; int n;
                for (int k = 0; k < 8; k++) begin
                    wd = $urandom; st = 4'($urandom); exp = model[k];
                    xact(0, BASE + 4 * k, wd, st, k < 7, rd, er, n);
                    model[k] = merge(exp, wd, st);
                    checks++;
                    if (rd !== exp || er !== 1'b0) begin errors++; $display("FAIL b2b a[%0d] got %h/%b want %h/0", k, rd, er, exp); end
                end
            end
            begin : pb
                logic [31:0] rd, wd, exp; logic [3:0] st; logic er; int n;
                for (int k = 0; k < 8; k++) begin
                    wd = $urandom; st = 4'($urandom); exp = model[8 + k];
                    xact(1, BASE + 4 * (8 + k), wd, st, k < 7, rd, er, n);
                    model[8 + k] = merge(exp, wd, st);
                    checks++;
                    if (rd !== exp || er !== 1'b0) begin errors++; $display("FAIL b2b b[%0d] got %h/%b want %h/0", k, rd, er, exp); end
                end
            end
        join
        same = 0; na = 0;
        foreach (order_q[i]) begin
            if (!order_q[i]) na++;
            if (i > 0 && order_q[i] == order_q[i-1]) same++;
        end
        checks += 3;
        if (order_q.size() != 16) begin errors++; $display("FAIL b2b responses got %0d want 16", order_q.size()); end
        if (na != 8) begin errors++; $display("FAIL b2b a responses got %0d want 8", na); end
        if (same != 0) begin errors++; $display("FAIL b2b alternation repeats got %0d want 0", same); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, newv; logic er; int n, seen;
        seen = 0;
        newv = ~model[9];
        a_valid = 1; a_addr = BASE + 8; a_wstrb = 0;
        @(posedge clk); @(negedge clk);
        seen += int'(a_ready);
        @(posedge clk); @(negedge clk);
        seen += int'(a_ready);
        rst = 1; a_valid = 0;
        b_valid = 1; b_addr = BASE + 36; b_wdata = newv; b_wstrb = 4'hF;
        @(posedge clk); @(negedge clk);
        seen += int'(a_ready) + int'(b_ready);
        rst = 0; b_valid = 0;
        repeat (8) begin @(negedge clk); seen += int'(a_ready) + int'(b_ready); end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid ready pulses got %0d want 0", seen); end
        xact(0, BASE + 8, 32'h0, 4'h0, 0, rd, er, n);
        checks += 2;
        if (rd !== model[2]) begin errors++; $display("FAIL rstmid readback rdata got %h want %h", rd, model[2]); end
        if (n != LAT) begin errors++; $display("FAIL rstmid latency got %0d want %0d", n, LAT); end
        xact(1, BASE + 36, 32'h0, 4'h0, 0, rd, er, n);
        checks++;
        if (rd !== model[9]) begin errors++; $display("FAIL rstmid no_commit rdata got %h want %h", rd, model[9]); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_byte_write();
        test_errors();
        test_random();
        test_simul();
        test_back_to_back();
        test_reset_mid();
        checks += 2;
        if (overlap != 0) begin errors++; $display("FAIL ready_overlap got %0d cycles want 0", overlap); end
        if (idle_bad != 0) begin errors++; $display("FAIL idle_outputs nonzero got %0d cycles want 0", idle_bad); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
